// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
// Module : irq_ctrl_pkg
// Brief  : Shared register offsets and constants for the interrupt controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package irq_ctrl_pkg;

  localparam int NSRC_DEFAULT = 6;

  localparam logic [1:0] IRQ_MODE  = 2'd0;
  localparam logic [1:0] IRQ_MASK  = 2'd1;
  localparam logic [1:0] IRQ_PEND  = 2'd2;
  localparam logic [1:0] IRQ_CLAIM = 2'd3;

  localparam int CLAIM_VALID_BIT = 31;

endpackage

`default_nettype wire

// File: rtl/irq_sync.sv
// ============================================================================
// Module : irq_sync
// Brief  : Multi-flop synchroniser for one IRQ line plus rise detector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_irq,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chain <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_chain[0] <= i_irq;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
      r_prev <= r_chain[SYNC_STAGES-1];
    end
  end

  assign o_level = r_chain[SYNC_STAGES-1];
  assign o_rise  = r_chain[SYNC_STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
// Module : irq_ctrl
// Brief  : Programmable level/edge interrupt controller driving CP0 HWInt.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC        = NSRC_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] IRQIn,
  input  logic [1:0]      Addr,
  input  logic            WE,
  input  logic            RE,
  input  logic [31:0]     WData,
  output logic [31:0]     RData,
  output logic [NSRC-1:0] HWInt
);

  localparam int IDW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0] r_mode;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_hwint;

  logic [NSRC-1:0] w_level;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_active;
  logic [NSRC-1:0] w_w1c;
  logic [NSRC-1:0] w_claim_clr;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_pend_nxt;
  logic [IDW-1:0]  w_id;
  logic            w_valid;
  logic            w_claim_fire;
  logic [31:0]     w_claim;
  logic            w_unused;

  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk    (clk),
      .reset  (reset),
      .i_irq  (IRQIn[g]),
      .o_level(w_level[g]),
      .o_rise (w_rise[g])
    );
  end

  assign w_active = r_pend & r_mask;

  // Ascending scan: the last hit is the highest-numbered, highest-priority source.
  always_comb begin
    w_id    = '0;
    w_valid = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_active[i]) begin
        w_id    = IDW'(i);
        w_valid = 1'b1;
      end
    end
  end

  always_comb begin
    w_claim                  = '0;
    w_claim[CLAIM_VALID_BIT] = w_valid;
    w_claim[IDW-1:0]         = w_id;
  end

  assign w_claim_fire = RE && (Addr == IRQ_CLAIM) && w_valid;
  assign w_claim_clr  = w_claim_fire ? (NSRC'(1) << w_id) : '0;
  assign w_w1c        = (WE && (Addr == IRQ_PEND)) ? WData[NSRC-1:0] : '0;
  assign w_clr        = w_w1c | w_claim_clr;

  // A new rise outranks a same-cycle clear so no event is dropped.
  assign w_pend_nxt = (r_mode & (w_rise | (r_pend & ~w_clr))) | (~r_mode & w_level);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode  <= '0;
      r_mask  <= '0;
      r_pend  <= '0;
      r_hwint <= '0;
    end else begin
      if (WE && (Addr == IRQ_MODE)) r_mode <= WData[NSRC-1:0];
      if (WE && (Addr == IRQ_MASK)) r_mask <= WData[NSRC-1:0];
      r_pend  <= w_pend_nxt;
      r_hwint <= r_pend & r_mask;
    end
  end

  assign HWInt = r_hwint;

  always_comb begin
    RData = '0;
    case (Addr)
      IRQ_MODE:  RData = 32'(r_mode);
      IRQ_MASK:  RData = 32'(r_mask);
      IRQ_PEND:  RData = 32'(r_pend);
      IRQ_CLAIM: RData = w_claim;
      default:   RData = '0;
    endcase
  end

  assign w_unused = ^WData[31:NSRC];

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
// Module : tb_irq_ctrl
// Brief  : Self-checking bench for irq_ctrl against a cycle-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_irq_ctrl;

  localparam int NSRC = 6;
  localparam int SYNC = 2;

  logic            clk;
  logic            reset;
  logic [NSRC-1:0] IRQIn;
  logic [1:0]      Addr;
  logic            WE;
  logic            RE;
  logic [31:0]     WData;
  logic [31:0]     RData;
  logic [NSRC-1:0] HWInt;

  int n_assert;
  int n_fail;

  // reference model state; hist[k] is IRQIn as sampled k+1 edges ago
  logic [NSRC-1:0] m_mode, m_mask, m_pend, m_hw;
  logic [NSRC-1:0] hist [0:SYNC];

  irq_ctrl #(.NSRC(NSRC), .SYNC_STAGES(SYNC)) dut (
    .clk  (clk),
    .reset(reset),
    .IRQIn(IRQIn),
    .Addr (Addr),
    .WE   (WE),
    .RE   (RE),
    .WData(WData),
    .RData(RData),
    .HWInt(HWInt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_mode = '0; m_mask = '0; m_pend = '0; m_hw = '0;
    for (int k = 0; k <= SYNC; k++) hist[k] = '0;
  endtask

  function automatic logic [31:0] m_claim();
    logic [NSRC-1:0] act;
    act = m_pend & m_mask;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) return 32'h8000_0000 | 32'(i);
    end
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_mode);
      2'd1:    return 32'(m_mask);
      2'd2:    return 32'(m_pend);
      default: return m_claim();
    endcase
  endfunction

  // One clock: evaluate the rules on the pre-edge state, advance, then compare HWInt.
  task automatic step();
    logic [NSRC-1:0] s, p, clr, np, nmode, nmask;
    logic [31:0]     cl;
    s  = hist[SYNC-1];
    p  = hist[SYNC];
    cl = m_claim();
    clr = '0;
    if (WE && Addr == 2'd2) clr = clr | WData[NSRC-1:0];
    if (RE && Addr == 2'd3 && cl[31]) clr[cl[2:0]] = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      if (m_mode[i]) np[i] = (s[i] & ~p[i]) | (m_pend[i] & ~clr[i]);
      else           np[i] = s[i];
    end
    nmode = (WE && Addr == 2'd0) ? WData[NSRC-1:0] : m_mode;
    nmask = (WE && Addr == 2'd1) ? WData[NSRC-1:0] : m_mask;
    @(posedge clk);
    m_hw   = m_pend & m_mask;
    m_pend = np;
    m_mode = nmode;
    m_mask = nmask;
    for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = IRQIn;
    #1;
    chk("hwint_model", 32'(HWInt), 32'(m_hw));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a; WData = d; WE = 1'b1;
    step();
    WE = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(tag, RData, exp);
    chk({tag, "_model"}, RData, m_read(a));
  endtask

  task automatic claim();
    Addr = 2'd3; RE = 1'b1;
    step();
    RE = 1'b0;
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    m_reset();
    reset = 1'b1; IRQIn = '0; Addr = '0; WE = 1'b0; RE = 1'b0; WData = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    chk("reset_hwint", 32'(HWInt), 32'h0);
    rd("reset_mode", 2'd0, 32'h0);
    rd("reset_claim", 2'd3, 32'h0);

    // level path
    wr(2'd1, 32'h04);
    IRQIn = 6'h04;
    steps(3);
    chk("level_hw_early", 32'(HWInt), 32'h0);
    step();
    chk("level_hw_on", 32'(HWInt), 32'h04);
    wr(2'd2, 32'h04);
    step();
    rd("level_w1c_noeffect", 2'd2, 32'h04);
    chk("level_hw_held", 32'(HWInt), 32'h04);
    IRQIn = 6'h00;
    steps(4);
    chk("level_hw_off", 32'(HWInt), 32'h0);

    // edge latch and claim
    wr(2'd0, 32'h3F);
    wr(2'd1, 32'h3F);
    IRQIn = 6'h02;
    step();
    IRQIn = 6'h00;
    steps(8);
    rd("edge_pend", 2'd2, 32'h02);
    chk("edge_hw", 32'(HWInt), 32'h02);
    steps(10);
    rd("edge_pend_hold", 2'd2, 32'h02);
    rd("edge_claim", 2'd3, 32'h8000_0001);
    claim();
    rd("edge_pend_cleared", 2'd2, 32'h0);
    step();
    chk("edge_hw_cleared", 32'(HWInt), 32'h0);

    // priority
    wr(2'd1, 32'h1F);
    IRQIn = 6'h29;
    step();
    IRQIn = 6'h00;
    steps(6);
    rd("prio_claim", 2'd3, 32'h8000_0003);
    claim();
    rd("prio_claim_next", 2'd3, 32'h8000_0000);
    rd("prio_pend5", 2'd2, 32'h21);
    wr(2'd2, 32'h3F);

    // race: W1C meets a fresh rise on source 0
    IRQIn = 6'h01;
    step();
    IRQIn = 6'h00;
    steps(6);
    rd("race_pre", 2'd2, 32'h01);
    IRQIn = 6'h01;
    steps(2);
    wr(2'd2, 32'h01);
    rd("race_set_wins", 2'd2, 32'h01);
    IRQIn = 6'h00;
    steps(3);
    wr(2'd2, 32'h3F);

    // masked events are retained
    wr(2'd1, 32'h00);
    IRQIn = 6'h10;
    step();
    IRQIn = 6'h00;
    steps(6);
    chk("mask_hw_zero", 32'(HWInt), 32'h0);
    rd("mask_pend", 2'd2, 32'h10);
    wr(2'd1, 32'h10);
    chk("mask_hw_not_yet", 32'(HWInt), 32'h0);
    step();
    chk("mask_hw_on", 32'(HWInt), 32'h10);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      Addr  = 2'($urandom_range(0, 3));
      WE    = ($urandom_range(0, 3) == 0);
      RE    = ($urandom_range(0, 2) == 0);
      WData = $urandom;
      if ($urandom_range(0, 3) == 0) IRQIn = IRQIn ^ 6'($urandom);
      #1;
      chk("rand_rdata", RData, m_read(Addr));
      step();
    end
    WE = 1'b0; RE = 1'b0;

    // asynchronous reset mid-cycle
    wr(2'd0, 32'h3F);
    wr(2'd1, 32'h3F);
    IRQIn = 6'h3F;
    steps(5);
    #2 reset = 1'b1;
    m_reset();
    #1;
    chk("areset_hwint", 32'(HWInt), 32'h0);
    rd("areset_mode", 2'd0, 32'h0);
    rd("areset_mask", 2'd1, 32'h0);
    rd("areset_pend", 2'd2, 32'h0);
    rd("areset_claim", 2'd3, 32'h0);
    reset = 1'b0;
    wr(2'd1, 32'h3F);
    steps(5);
    chk("post_reset_level", 32'(HWInt), 32'h3F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
